regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 121 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Two-write-port register file with a per-entry busy scoreboard for tracking
// outstanding producers, optional same-cycle write-to-read forwarding and a hardwired zero register.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic [ADDR_W-1:0] rdA_addr,
    input  logic [ADDR_W-1:0] rdB_addr,
    output logic [DATA_W-1:0] rdA_data,
    output logic [DATA_W-1:0] rdB_data,
    output logic              rdA_busy,
    output logic              rdB_busy,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic [ADDR_W:0]   pending_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    function automatic logic [ADDR_W:0] count_ones(input logic [DEPTH-1:0] b);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{ADDR_W{1'b0}}, b[i]};
        end
        return c;
    endfunction

    // Next state: wr1 first so wr0 overrides on a shared index; issue last so set beats clear.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (wr1_en) begin
            mem_d[wr1_addr]  = wr1_data;
            busy_d[wr1_addr] = 1'b0;
        end
        if (wr0_en) begin
            mem_d[wr0_addr]  = wr0_data;
            busy_d[wr0_addr] = 1'b0;
        end
        if (issue_en) begin
            busy_d[issue_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            mem_d[0]  = '0;
            busy_d[0] = 1'b0;
        end
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            busy_d = '0;
        end
        cnt_d = count_ones(busy_d);
    end

    always_ff @(posedge clk) begin
        mem_q  <= mem_d;
        busy_q <= busy_d;
        cnt_q  <= cnt_d;
    end

    // Read ports: forwarded data also masks busy, since the producer is completing now.
    always_comb begin
        rdA_data = mem_q[rdA_addr];
        rdA_busy = busy_q[rdA_addr];
        if (BYPASS != 0) begin
            if (wr0_en && wr0_addr == rdA_addr) begin
                rdA_data = wr0_data;
                rdA_busy = 1'b0;
            end else if (wr1_en && wr1_addr == rdA_addr) begin
                rdA_data = wr1_data;
                rdA_busy = 1'b0;
            end
        end
        if (is_zero_reg(rdA_addr)) begin
            rdA_data = '0;
            rdA_busy = 1'b0;
        end
    end

    always_comb begin
        rdB_data = mem_q[rdB_addr];
        rdB_busy = busy_q[rdB_addr];
        if (BYPASS != 0) begin
            if (wr0_en && wr0_addr == rdB_addr) begin
                rdB_data = wr0_data;
                rdB_busy = 1'b0;
            end else if (wr1_en && wr1_addr == rdB_addr) begin
                rdB_data = wr1_data;
                rdB_busy = 1'b0;
            end
        end
        if (is_zero_reg(rdB_addr)) begin
            rdB_data = '0;
            rdB_busy = 1'b0;
        end
    end

    assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one task per scenario with inline checks.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr0_en, wr1_en, issue_en;
    logic [4:0]  wr0_addr, wr1_addr, rdA_addr, rdB_addr, issue_addr;
    logic [31:0] wr0_data, wr1_data, rdA_data, rdB_data;
    logic        rdA_busy, rdB_busy;
    logic [5:0]  pending_cnt;

    int errors = 0;
    int checks = 0;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .reset(reset),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rdA_addr(rdA_addr), .rdB_addr(rdB_addr),
        .rdA_data(rdA_data), .rdB_data(rdB_data),
        .rdA_busy(rdA_busy), .rdB_busy(rdB_busy),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        issue_en = 1'b0; issue_addr = '0;
    endtask

    task automatic test_reset;
        reset = 1'b1; idle(); rdA_addr = 5'd5; rdB_addr = 5'd7;
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++; if (pending_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt actual=%0d required=0", pending_cnt); end
        checks++; if (rdA_data !== 32'd0) begin errors++; $display("FAIL reset_rdA actual=%h required=0", rdA_data); end
        checks++; if (rdA_busy !== 1'b0) begin errors++; $display("FAIL reset_busyA actual=%b required=0", rdA_busy); end
    endtask

    task automatic test_write_read;
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        tick(); idle(); rdA_addr = 5'd5; #1;
        checks++; if (rdA_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_data actual=%h required=deadbeef", rdA_data); end
        checks++; if (rdA_busy !== 1'b0) begin errors++; $display("FAIL wr_rd_busy actual=%b required=0", rdA_busy); end
    endtask

    task automatic test_dual_write_same;
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22;
        rdB_addr = 5'd7; #1;
        checks++; if (rdB_data !== 32'h11) begin errors++; $display("FAIL dual_fwd actual=%h required=11", rdB_data); end
        tick(); idle(); #1;
        checks++; if (rdB_data !== 32'h11) begin errors++; $display("FAIL dual_store actual=%h required=11", rdB_data); end
    endtask

    task automatic test_dual_write_diff;
        wr0_en = 1'b1; wr0_addr = 5'd10; wr0_data = 32'hA0A0;
        wr1_en = 1'b1; wr1_addr = 5'd11; wr1_data = 32'hB1B1;
        rdA_addr = 5'd11; #1;
        checks++; if (rdA_data !== 32'hB1B1) begin errors++; $display("FAIL wr1_fwd actual=%h required=b1b1", rdA_data); end
        tick(); idle(); rdA_addr = 5'd10; rdB_addr = 5'd11; #1;
        checks++; if (rdA_data !== 32'hA0A0) begin errors++; $display("FAIL diff_r10 actual=%h required=a0a0", rdA_data); end
        checks++; if (rdB_data !== 32'hB1B1) begin errors++; $display("FAIL diff_r11 actual=%h required=b1b1", rdB_data); end
    endtask

    task automatic test_issue_clear;
        issue_en = 1'b1; issue_addr = 5'd9; rdA_addr = 5'd9; #1;
        checks++; if (rdA_busy !== 1'b0) begin errors++; $display("FAIL issue_same_cycle_busy actual=%b required=0", rdA_busy); end
        tick(); idle(); #1;
        checks++; if (rdA_busy !== 1'b1) begin errors++; $display("FAIL issue_busy actual=%b required=1", rdA_busy); end
        checks++; if (pending_cnt !== 6'd1) begin errors++; $display("FAIL issue_cnt actual=%0d required=1", pending_cnt); end
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h5; #1;
        checks++; if (rdA_busy !== 1'b0) begin errors++; $display("FAIL fwd_busy actual=%b required=0", rdA_busy); end
        checks++; if (rdA_data !== 32'h5) begin errors++; $display("FAIL fwd_data actual=%h required=5", rdA_data); end
        tick(); idle(); #1;
        checks++; if (pending_cnt !== 6'd0) begin errors++; $display("FAIL clear_cnt actual=%0d required=0", pending_cnt); end
        checks++; if (rdA_busy !== 1'b0) begin errors++; $display("FAIL clear_busy actual=%b required=0", rdA_busy); end
    endtask

    task automatic test_issue_write_same;
        issue_en = 1'b1; issue_addr = 5'd3;
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hAB;
        tick(); idle(); rdA_addr = 5'd3; #1;
        checks++; if (rdA_data !== 32'hAB) begin errors++; $display("FAIL setwin_data actual=%h required=ab", rdA_data); end
        checks++; if (rdA_busy !== 1'b1) begin errors++; $display("FAIL setwin_busy actual=%b required=1", rdA_busy); end
        checks++; if (pending_cnt !== 6'd1) begin errors++; $display("FAIL setwin_cnt actual=%0d required=1", pending_cnt); end
        wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'hCD;
        tick(); idle(); #1;
        checks++; if (pending_cnt !== 6'd0) begin errors++; $display("FAIL setwin_release actual=%0d required=0", pending_cnt); end
    endtask

    task automatic test_zero_reg;
        issue_en = 1'b1; issue_addr = 5'd0;
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFF;
        rdA_addr = 5'd0; #1;
        checks++; if (rdA_data !== 32'd0) begin errors++; $display("FAIL zero_fwd actual=%h required=0", rdA_data); end
        tick(); idle(); #1;
        checks++; if (rdA_data !== 32'd0) begin errors++; $display("FAIL zero_data actual=%h required=0", rdA_data); end
        checks++; if (rdA_busy !== 1'b0) begin errors++; $display("FAIL zero_busy actual=%b required=0", rdA_busy); end
        checks++; if (pending_cnt !== 6'd0) begin errors++; $display("FAIL zero_cnt actual=%0d required=0", pending_cnt); end
    endtask

    task automatic test_back_to_back;
        issue_en = 1'b1; issue_addr = 5'd12;
        tick();
        tick(); idle(); rdB_addr = 5'd12; #1;
        checks++; if (pending_cnt !== 6'd1) begin errors++; $display("FAIL reissue_cnt actual=%0d required=1", pending_cnt); end
        checks++; if (rdB_busy !== 1'b1) begin errors++; $display("FAIL reissue_busy actual=%b required=1", rdB_busy); end
        wr0_en = 1'b1; wr0_addr = 5'd12; wr0_data = 32'h1234;
        issue_en = 1'b1; issue_addr = 5'd13;
        tick(); idle(); #1;
        checks++; if (rdB_busy !== 1'b0) begin errors++; $display("FAIL b2b_r12_busy actual=%b required=0", rdB_busy); end
        checks++; if (pending_cnt !== 6'd1) begin errors++; $display("FAIL b2b_cnt actual=%0d required=1", pending_cnt); end
        wr0_en = 1'b1; wr0_addr = 5'd13; wr0_data = 32'h5678;
        tick(); idle(); #1;
        checks++; if (pending_cnt !== 6'd0) begin errors++; $display("FAIL b2b_clear actual=%0d required=0", pending_cnt); end
    endtask

    task automatic test_reset_midflight;
        for (int i = 1; i < 32; i++) begin
            issue_en = 1'b1; issue_addr = 5'(i);
            tick();
        end
        idle(); rdA_addr = 5'd20; #1;
        checks++; if (pending_cnt !== 6'd31) begin errors++; $display("FAIL full_cnt actual=%0d required=31", pending_cnt); end
        checks++; if (rdA_busy !== 1'b1) begin errors++; $display("FAIL full_busy actual=%b required=1", rdA_busy); end
        reset = 1'b1;
        wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'h99;
        issue_en = 1'b1; issue_addr = 5'd6;
        tick(); reset = 1'b0; idle();
        rdA_addr = 5'd5; rdB_addr = 5'd4; #1;
        checks++; if (pending_cnt !== 6'd0) begin errors++; $display("FAIL post_reset_cnt actual=%0d required=0", pending_cnt); end
        checks++; if (rdA_data !== 32'd0) begin errors++; $display("FAIL post_reset_r5 actual=%h required=0", rdA_data); end
        checks++; if (rdB_data !== 32'd0) begin errors++; $display("FAIL post_reset_r4 actual=%h required=0", rdB_data); end
        checks++; if (rdA_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy5 actual=%b required=0", rdA_busy); end
        rdA_addr = 5'd6; rdB_addr = 5'd7; #1;
        checks++; if (rdA_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy6 actual=%b required=0", rdA_busy); end
        checks++; if (rdB_data !== 32'd0) begin errors++; $display("FAIL post_reset_r7 actual=%h required=0", rdB_data); end
    endtask

    initial begin
        reset = 1'b1; idle(); rdA_addr = '0; rdB_addr = '0;
        test_reset();
        test_write_read();
        test_dual_write_same();
        test_dual_write_diff();
        test_issue_clear();
        test_issue_write_same();
        test_zero_reg();
        test_back_to_back();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
